// File: rtl/s2a_burst_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst controller and the interconnect.
interface s2a_burst_ctrl_if #(
  parameter int unsigned DW = 64
) ();
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic            wlast;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/s2a_burst_ctrl.sv
// Stream-to-AXI burst writer: buffers stream samples and writes them as fixed INCR bursts into a
// ring of isize bursts at ibase. Define S2A_BRESP_EN to wait for and check the B response.
module s2a_burst_ctrl #(
  parameter int unsigned DW         = 64,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic          AXI_clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          Ien,
  input  logic [DW-1:0] Idata,
  input  logic [31:0]   ibase,
  input  logic [17:0]   isize,
  output logic [17:0]   iacnt,
  output logic [31:0]   ibcnt,
  output logic          ovf,
  output logic          berr,
  s2a_burst_ctrl_if.master axi
);

  localparam int unsigned BeatBytes  = DW / 8;
  localparam int unsigned AddrShift  = $clog2(BURST_LEN * BeatBytes);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PtrW + 1;
  localparam logic [7:0]  LastBeat   = 8'(BURST_LEN - 1);
  localparam logic [CntW-1:0] BurstLevel = CntW'(BURST_LEN);
  localparam logic [CntW-1:0] FullLevel  = CntW'(FIFO_DEPTH);
  localparam logic [2:0]  AwSize     = 3'($clog2(BeatBytes));

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  logic [DW-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  logic            sync_pend_q;
  logic [7:0]      beat_q;
  logic            awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [31:0]     awaddr_q;
  logic [17:0]     iacnt_q;
  logic [31:0]     ibcnt_q;
  logic            ovf_q, berr_q;

  logic        hold_off, clear, pop, full, push, drop;
  logic [17:0] isize_last;
  logic [31:0] burst_off;

  // A pending restart freezes stream intake until the clear lands in IDLE.
  assign hold_off   = sync | sync_pend_q;
  assign clear      = (state_q == StIdle) & hold_off;
  assign pop        = (state_q == StData) & wvalid_q & axi.wready;
  assign full       = (count_q == FullLevel);
  assign push       = Ien & ~hold_off & (~full | pop);
  assign drop       = Ien & ~hold_off & full & ~pop;
  assign isize_last = (isize == 18'd0) ? 18'd0 : isize - 18'd1;
  assign burst_off  = {14'd0, iacnt_q} << AddrShift;

  always_ff @(posedge AXI_clk) begin
    if (push) mem_q[wr_ptr_q] <= Idata;
  end

  always_ff @(posedge AXI_clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      sync_pend_q <= 1'b0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= '0;
      iacnt_q     <= '0;
      ibcnt_q     <= '0;
      ovf_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
`ifndef S2A_BRESP_EN
      bready_q <= 1'b1;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (drop) ovf_q <= 1'b1;
      if (sync && state_q != StIdle) sync_pend_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iacnt_q     <= '0;
            ibcnt_q     <= '0;
            ovf_q       <= 1'b0;
            berr_q      <= 1'b0;
            sync_pend_q <= 1'b0;
          end else if (count_q >= BurstLevel) begin
            awaddr_q  <= ibase + burst_off;
            awvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b0;
            beat_q    <= '0;
            state_q   <= StData;
            if (iacnt_q == isize_last) begin
              iacnt_q <= '0;
              ibcnt_q <= ibcnt_q + 32'd1;
            end else begin
              iacnt_q <= iacnt_q + 18'd1;
            end
          end
        end
        StData: begin
          if (pop) begin
            beat_q <= beat_q + 8'd1;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
`ifdef S2A_BRESP_EN
              bready_q <= 1'b1;
              state_q  <= StResp;
`else
              state_q  <= StIdle;
`endif
            end else if (beat_q + 8'd1 == LastBeat) begin
              wlast_q <= 1'b1;
            end
          end
        end
        StResp: begin
`ifdef S2A_BRESP_EN
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            if (axi.bresp != 2'b00) berr_q <= 1'b1;
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifndef S2A_BRESP_EN
  logic unused_b;
  assign unused_b = ^{axi.bresp, axi.bvalid};
`endif

  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = LastBeat;
  assign axi.awsize  = AwSize;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = mem_q[rd_ptr_q];
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.wlast   = wlast_q;
  assign axi.bready  = bready_q;
  assign iacnt       = iacnt_q;
  assign ibcnt       = ibcnt_q;
  assign ovf         = ovf_q;
  assign berr        = berr_q;

endmodule

// File: tb/tb_s2a_burst_ctrl.sv
// Scoreboard bench for s2a_burst_ctrl: stimulus queues expected AW addresses and W beats, a
// negedge monitor pops and compares on every handshake. Honours S2A_BRESP_EN.
module tb_s2a_burst_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned BL = 16;
  localparam int unsigned FD = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sync = 1'b0;
  logic          Ien = 1'b0;
  logic [DW-1:0] Idata = '0;
  logic [31:0]   ibase = '0;
  logic [17:0]   isize = 18'd4;
  logic [17:0]   iacnt;
  logic [31:0]   ibcnt;
  logic          ovf, berr;

  s2a_burst_ctrl_if #(.DW(DW)) axi ();

  s2a_burst_ctrl #(.DW(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .AXI_clk (clk),
    .rst     (rst),
    .sync    (sync),
    .Ien     (Ien),
    .Idata   (Idata),
    .ibase   (ibase),
    .isize   (isize),
    .iacnt   (iacnt),
    .ibcnt   (ibcnt),
    .ovf     (ovf),
    .berr    (berr),
    .axi     (axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0]   exp_aw[$];
  logic [DW-1:0] exp_w[$];
  int w_total = 0, aw_bursts = 0, w_bursts = 0, b_issued = 0, b_done = 0, beat_idx = 0;
  logic aw_wait = 1'b0, w_wait = 1'b0;
  logic [31:0]   aw_prev;
  logic [DW-1:0] w_prev;
  logic stall_mode = 1'b0, b_hold = 1'b0;
  logic [1:0] bresp_sel = 2'b00;
  logic [DW-1:0] next_val;
  int w0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: handshakes happen at the next posedge, so sampling here sees what will transfer.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      aw_wait = 1'b0; w_wait = 1'b0; aw_bursts = 0; w_bursts = 0;
      beat_idx = 0; b_issued = 0; b_done = 0;
    end else begin
      if (axi.awvalid) begin
        if (aw_wait) chk("awaddr_stable", 64'(axi.awaddr), 64'(aw_prev));
        chk("aw_one_outstanding", 64'(aw_bursts), 64'(w_bursts));
        if (axi.awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 64'(axi.awaddr), 64'hDEAD);
          else chk("awaddr", 64'(axi.awaddr), 64'(exp_aw.pop_front()));
          chk("awlen", 64'(axi.awlen), 64'(BL - 1));
          chk("awsize", 64'(axi.awsize), 64'd3);
          chk("awburst", 64'(axi.awburst), 64'd1);
          aw_bursts++;
          aw_wait = 1'b0;
        end else begin
          aw_wait = 1'b1;
          aw_prev = axi.awaddr;
        end
      end
      if (axi.wvalid) begin
        chk("w_after_aw", 64'(aw_bursts > w_bursts), 64'd1);
        if (w_wait) chk("wdata_stable", 64'(axi.wdata), 64'(w_prev));
        if (axi.wready) begin
          if (exp_w.size() == 0) chk("w_unexpected", 64'(axi.wdata), 64'hDEAD);
          else chk("wdata", 64'(axi.wdata), 64'(exp_w.pop_front()));
          chk("wlast", 64'(axi.wlast), 64'(beat_idx == BL - 1));
          chk("wstrb", 64'(axi.wstrb), 64'hff);
          w_total++;
          if (beat_idx == BL - 1) begin
            beat_idx = 0; w_bursts++; b_issued++;
          end else begin
            beat_idx++;
          end
          w_wait = 1'b0;
        end else begin
          w_wait = 1'b1;
          w_prev = axi.wdata;
        end
      end
      if (axi.bvalid && axi.bready) b_done++;
    end
  end

  // B responder: one response per completed burst, optionally held off.
  initial begin
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
    forever begin
      @(posedge clk); #1;
      axi.bvalid = !b_hold && (b_done != b_issued);
      axi.bresp  = bresp_sel;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (stall_mode) begin
      axi.awready = 1'($urandom_range(0, 1));
      axi.wready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send(input int n, input int n_acc, input bit gaps);
    for (int i = 0; i < n; i++) begin
      Ien = 1'b1;
      Idata = next_val;
      if (i < n_acc) exp_w.push_back(next_val);
      next_val = next_val + 1;
      tick(1);
      Ien = 1'b0;
      if (gaps) tick($urandom_range(2, 4));
    end
  endtask

  task automatic wait_w(input int target, input string name);
    int n = 0;
    while (w_total < target && n < 3000) begin
      tick(1);
      n++;
    end
    chk(name, 64'(w_total), 64'(target));
  endtask

  initial begin
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    next_val = 64'hC0DE_0000_0000_0000;
    do_reset;

    chk("rst_iacnt", 64'(iacnt), 64'd0);
    chk("rst_ibcnt", 64'(ibcnt), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_berr", 64'(berr), 64'd0);
    chk("rst_awvalid", 64'(axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(axi.wvalid), 64'd0);
    chk("rst_wlast", 64'(axi.wlast), 64'd0);
    chk("rst_bready", 64'(axi.bready), 64'd0);
    chk("rst_awaddr", 64'(axi.awaddr), 64'd0);

    // Single burst
    ibase = 32'h1000_0000;
    isize = 18'd4;
    w0 = w_total;
    exp_aw.push_back(32'h1000_0000);
    send(16, 16, 1'b0);
    wait_w(w0 + 16, "t1_beats");
    tick(3);
    chk("t1_iacnt", 64'(iacnt), 64'd1);
    chk("t1_ibcnt", 64'(ibcnt), 64'd0);
`ifndef S2A_BRESP_EN
    chk("t1_bready_tied", 64'(axi.bready), 64'd1);
`endif

    // Ring wrap over five bursts
    do_reset;
    w0 = w_total;
    for (int k = 0; k < 5; k++) exp_aw.push_back(32'h1000_0000 + 32'((k % 4) * 32'h80));
    send(80, 80, 1'b0);
    wait_w(w0 + 80, "t2_beats");
    tick(3);
    chk("t2_iacnt", 64'(iacnt), 64'd1);
    chk("t2_ibcnt", 64'(ibcnt), 64'd1);
    chk("t2_ovf", 64'(ovf), 64'd0);

    // Overflow with the bus fully stalled
    do_reset;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    w0 = w_total;
    exp_aw.push_back(32'h1000_0000);
    exp_aw.push_back(32'h1000_0080);
    send(40, 32, 1'b0);
    tick(2);
    chk("t3_ovf_set", 64'(ovf), 64'd1);
    chk("t3_awvalid_stalled", 64'(axi.awvalid), 64'd1);
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    wait_w(w0 + 32, "t3_beats");
    tick(3);
    chk("t3_iacnt", 64'(iacnt), 64'd2);
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);

    // Restart during DATA: burst finishes, then everything is cleared
    axi.wready = 1'b0;
    w0 = w_total;
    exp_aw.push_back(32'h1000_0100);
    send(20, 16, 1'b0);
    begin
      int n = 0;
      while (!axi.wvalid && n < 200) begin
        tick(1);
        n++;
      end
    end
    chk("t4_wvalid_seen", 64'(axi.wvalid), 64'd1);
    sync = 1'b1;
    Ien = 1'b1;
    Idata = next_val;
    next_val = next_val + 1;
    tick(1);
    sync = 1'b0;
    Ien = 1'b0;
    tick(2);
    axi.wready = 1'b1;
    wait_w(w0 + 16, "t4_beats");
    tick(4);
    chk("t4_iacnt", 64'(iacnt), 64'd0);
    chk("t4_ibcnt", 64'(ibcnt), 64'd0);
    chk("t4_ovf", 64'(ovf), 64'd0);
    // Leftover beats must be gone: 12 more stay below one burst
    send(12, 12, 1'b0);
    tick(20);
    chk("t4_no_burst", 64'(axi.awvalid), 64'd0);

    // Random ready stalls
    w0 = w_total - 0;
    exp_aw.push_back(32'h1000_0000);
    exp_aw.push_back(32'h1000_0080);
    exp_aw.push_back(32'h1000_0100);
    stall_mode = 1'b1;
    send(36, 36, 1'b1);
    wait_w(w0 + 48, "t5_beats");
    stall_mode = 1'b0;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    tick(4);
    chk("t5_iacnt", 64'(iacnt), 64'd3);
    chk("t5_ovf", 64'(ovf), 64'd0);

    // isize = 0 behaves as a one-burst ring
    do_reset;
    ibase = 32'h2000_0000;
    isize = 18'd0;
    w0 = w_total;
    exp_aw.push_back(32'h2000_0000);
    exp_aw.push_back(32'h2000_0000);
    send(32, 32, 1'b0);
    wait_w(w0 + 32, "t6_beats");
    tick(3);
    chk("t6_iacnt", 64'(iacnt), 64'd0);
    chk("t6_ibcnt", 64'(ibcnt), 64'd2);

    // Error response, held off
    isize = 18'd4;
    bresp_sel = 2'b10;
    b_hold = 1'b1;
    w0 = w_total;
    exp_aw.push_back(32'h2000_0000);
    exp_aw.push_back(32'h2000_0080);
    send(32, 32, 1'b0);
    wait_w(w0 + 16, "t7_first_burst");
    tick(10);
`ifdef S2A_BRESP_EN
    chk("t7_no_aw_in_resp", 64'(axi.awvalid), 64'd0);
    chk("t7_bready", 64'(axi.bready), 64'd1);
    chk("t7_berr_pending", 64'(berr), 64'd0);
`endif
    b_hold = 1'b0;
    wait_w(w0 + 32, "t7_beats");
    tick(4);
`ifdef S2A_BRESP_EN
    chk("t7_berr", 64'(berr), 64'd1);
`else
    chk("t7_berr_held", 64'(berr), 64'd0);
    chk("t7_bready_tied", 64'(axi.bready), 64'd1);
`endif
    bresp_sel = 2'b00;
    tick(4);

    chk("aw_queue_empty", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_empty", 64'(exp_w.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
